fsm_ctrl_mc: RTL

Multi-channel job-control FSM. Provides NUM_CH independent IDLE/RUN/DONE/FAULT controllers in one block, with a per-channel RUN timeout watchdog, bounded automatic retry, a latched fault cause and an explicit fault-clear handshake. Sits between the sequencer issuing start/done/fault events and the status/interrupt logic, which consumes the busy/error flags and the aggregate summaries.

---
 rtl/fsm_ctrl_mc_if.sv | 27 ++
 rtl/fsm_ctrl_mc.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/fsm_ctrl_mc_if.sv
// rtl/fsm_ctrl_mc_if.sv - event and status bundle between sequencer, fsm_ctrl_mc and status logic
interface fsm_ctrl_mc_if #(
   parameter int NUM_CH = 4,
   parameter int CNT_W  = $clog2(NUM_CH + 1)
);
   logic [NUM_CH-1:0]   in_start;
   logic [NUM_CH-1:0]   in_done;
   logic [NUM_CH-1:0]   in_fault;
   logic [NUM_CH-1:0]   in_clr;
   logic [NUM_CH-1:0]   out_busy;
   logic [NUM_CH-1:0]   out_error;
   logic [NUM_CH-1:0]   out_retry;
   logic [2*NUM_CH-1:0] err_code;
   logic [3*NUM_CH-1:0] state_q;
   logic                any_error;
   logic [CNT_W-1:0]    busy_cnt;

   modport master (
      output in_start, in_done, in_fault, in_clr,
      input  out_busy, out_error, out_retry, err_code, state_q, any_error, busy_cnt
   );

   modport slave (
      input  in_start, in_done, in_fault, in_clr,
      output out_busy, out_error, out_retry, err_code, state_q, any_error, busy_cnt
   );
endinterface

// File: rtl/fsm_ctrl_mc.sv
// rtl/fsm_ctrl_mc.sv - NUM_CH independent job controllers with RUN watchdog, bounded retry and latched fault cause
module fsm_ctrl_mc #(
   parameter int NUM_CH      = 4,
   parameter int TIMEOUT_CYC = 16,
   parameter int MAX_RETRY   = 2
) (
   input  logic         clk,
   input  logic         rst,
   fsm_ctrl_mc_if.slave bus
);
   localparam int TMR_W = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
   localparam int RTY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
   localparam int CNT_W = $clog2(NUM_CH + 1);
   localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);
   localparam logic [TMR_W-1:0] TMR_ONE  = TMR_W'(1);
   localparam logic [RTY_W-1:0] RTY_MAX  = RTY_W'(MAX_RETRY);
   localparam logic [RTY_W-1:0] RTY_ONE  = RTY_W'(1);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_RUN   = 3'd1,
      ST_DONE  = 3'd2,
      ST_RETRY = 3'd3,
      ST_FAULT = 3'd4
   } state_t;

   logic [3*NUM_CH-1:0] r_state;
   logic [3*NUM_CH-1:0] w_nxt_all;
   logic [CNT_W-1:0]    w_busy_cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= '0;
      else     r_state <= w_nxt_all;
   end

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      state_t           w_cur;
      state_t           w_nxt;
      logic [TMR_W-1:0] r_tmr;
      logic [RTY_W-1:0] r_rty;
      logic [1:0]       r_err;
      logic [1:0]       w_err_nxt;
      logic             w_tmo;
      logic             w_legal;

      assign w_cur   = state_t'(r_state[3*g +: 3]);
      assign w_legal = (r_state[3*g +: 3] <= 3'd4);
      assign w_tmo   = (TIMEOUT_CYC > 0) && (r_tmr == TMR_LAST);

      // Priority inside every state: fault, then done, then watchdog.
      always_comb begin
         w_nxt     = ST_IDLE;
         w_err_nxt = r_err;
         case (w_cur)
            ST_IDLE: begin
               if (bus.in_fault[g]) begin
                  w_nxt     = ST_FAULT;
                  w_err_nxt = 2'd1;
               end else if (bus.in_start[g]) begin
                  w_nxt = ST_RUN;
               end
            end
            ST_RUN: begin
               if (bus.in_fault[g]) begin
                  w_nxt     = ST_FAULT;
                  w_err_nxt = 2'd1;
               end else if (bus.in_done[g]) begin
                  w_nxt = ST_DONE;
               end else if (w_tmo) begin
                  if (r_rty < RTY_MAX) begin
                     w_nxt = ST_RETRY;
                  end else begin
                     w_nxt     = ST_FAULT;
                     w_err_nxt = 2'd2;
                  end
               end else begin
                  w_nxt = ST_RUN;
               end
            end
            ST_RETRY: begin
               if (bus.in_fault[g]) begin
                  w_nxt     = ST_FAULT;
                  w_err_nxt = 2'd1;
               end else begin
                  w_nxt = ST_RUN;
               end
            end
            ST_DONE: begin
               if (bus.in_fault[g]) begin
                  w_nxt     = ST_FAULT;
                  w_err_nxt = 2'd1;
               end else if (bus.in_start[g]) begin
                  w_nxt = ST_DONE;
               end
            end
            ST_FAULT: begin
               if (bus.in_clr[g] && !bus.in_fault[g] && !bus.in_start[g]) begin
                  w_nxt     = ST_IDLE;
                  w_err_nxt = 2'd0;
               end else begin
                  w_nxt = ST_FAULT;
               end
            end
            default: begin
               w_nxt     = ST_IDLE;
               w_err_nxt = 2'd0;
            end
         endcase
      end

      // Timer restarts on every entry into RUN; retry count only resets for a new job.
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            r_tmr <= '0;
            r_rty <= '0;
            r_err <= 2'd0;
         end else begin
            r_err <= w_err_nxt;
            if (w_nxt == ST_RUN && w_cur != ST_RUN)
               r_tmr <= '0;
            else if (w_cur == ST_RUN && r_tmr != '1)
               r_tmr <= r_tmr + TMR_ONE;
            if (w_cur == ST_IDLE && w_nxt == ST_RUN)
               r_rty <= '0;
            else if (w_cur == ST_RETRY && r_rty != '1)
               r_rty <= r_rty + RTY_ONE;
         end
      end

      assign w_nxt_all[3*g +: 3]    = w_nxt;
      assign bus.out_busy[g]        = (w_cur == ST_RUN) || (w_cur == ST_RETRY);
      assign bus.out_retry[g]       = (w_cur == ST_RETRY);
      assign bus.out_error[g]       = (w_cur == ST_FAULT);
      assign bus.err_code[2*g +: 2] = w_legal ? r_err : 2'd0;
      assign bus.state_q[3*g +: 3]  = r_state[3*g +: 3];
   end

   always_comb begin
      w_busy_cnt = '0;
      for (int i = 0; i < NUM_CH; i++)
         w_busy_cnt = w_busy_cnt + CNT_W'(bus.out_busy[i]);
   end

   assign bus.busy_cnt  = w_busy_cnt;
   assign bus.any_error = |bus.out_error;
endmodule
